// File: rtl/syscall_pkg.sv
// Shared syscall definitions: syscall codes used by the input and output
// controllers, the read-integer FSM state encoding and a width helper.
package syscall_pkg;

    // Register data width of the CPU.
    localparam int unsigned REG_W = 32;

    // $v0 syscall codes understood by the syscall controllers.
    localparam logic [REG_W-1:0] SYSCALL_PRINT_INT = 32'd1;
    localparam logic [REG_W-1:0] SYSCALL_READ_INT  = 32'd5;
    localparam logic [REG_W-1:0] SYSCALL_EXIT      = 32'd10;

    // Read-integer controller states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_WAIT_PRESS = 3'd2,
        ST_DEBOUNCE   = 3'd3,
        ST_WRITE      = 3'd4
    } input_state_t;

    // Bits needed to hold a count of 0..cycles (at least one bit).
    function automatic int unsigned count_width(input int unsigned cycles);
        if (cycles < 1) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/syscall_input_debounce.sv
// button_debounce: two-flop synchronizer for the raw confirm button plus a
// saturating counter of consecutive synchronized-high samples.
// stable_c fires on the sample that brings the run length to DEBOUNCE_CYCLES.
module button_debounce
    import syscall_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic confirm,
    input  logic clear,
    output logic sync_confirm,
    output logic stable_c
);

    localparam int unsigned    CNT_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Two-stage synchronizer for the asynchronous push-button.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta    <= 1'b0;
            sync_confirm <= 1'b0;
        end else begin
            sync_meta    <= confirm;
            sync_confirm <= sync_meta;
        end
    end

    // Run length of synchronized highs; a low sample or clear restarts it.
    always_comb begin
        count_next = count;
        if (clear || !sync_confirm) begin
            count_next = '0;
        end else if (count != CNT_MAX) begin
            count_next = count + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Sample that completes the required run; saturation keeps it one-shot.
    assign stable_c = sync_confirm && !clear && (count == CNT_LAST);

endmodule

// File: rtl/syscall_input.sv
// syscall_input: read-integer syscall service. Stalls the CPU on a
// read-int syscall, waits for a debounced confirm press and writes the
// switch value into $v0 with a one-cycle regWrite strobe.
// Build option: define SYSCALL_INPUT_SIGN_EXT_EN to sign-extend the switch
// value from bit SWITCH_W-1; otherwise it is zero-extended.
// enable is combinational so the CPU stalls in the syscall cycle itself.
module syscall_input
    import syscall_pkg::*;
#(
    parameter logic [31:0] READ_CODE       = SYSCALL_READ_INT,
    parameter int unsigned SWITCH_W        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                syscall,
    input  logic [REG_W-1:0]    regSValue,
    input  logic [SWITCH_W-1:0] switches,
    input  logic                confirm,
    output logic                enable,
    output logic                regWrite,
    output logic [REG_W-1:0]    writeValue,
    output logic                waiting
);

    input_state_t     state_q;
    input_state_t     state_d;
    logic             reg_write_d;
    logic             waiting_d;
    logic [REG_W-1:0] value_d;
    logic [REG_W-1:0] ext_value;
    logic             trigger_c;
    logic             clear_c;
    logic             sync_confirm;
    logic             stable_c;

    // Button conditioning; the counter only runs while a press is being judged.
    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .confirm     (confirm),
        .clear       (clear_c),
        .sync_confirm(sync_confirm),
        .stable_c    (stable_c)
    );

    // Widen the switch value to register width.
`ifdef SYSCALL_INPUT_SIGN_EXT_EN
    assign ext_value = REG_W'($signed(switches));
`else
    assign ext_value = REG_W'(switches);
`endif

    // Read-integer request decode.
    assign trigger_c = syscall && (regSValue == READ_CODE);

    // Next-state, stall and registered-output decode.
    always_comb begin
        state_d     = state_q;
        reg_write_d = 1'b0;
        value_d     = writeValue;
        clear_c     = 1'b1;
        enable      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (trigger_c) begin
                    enable  = 1'b0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // Button still held from an earlier read must be released first.
                enable = 1'b0;
                if (!sync_confirm) begin
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                enable  = 1'b0;
                clear_c = 1'b0;
                if (stable_c) begin
                    state_d     = ST_WRITE;
                    reg_write_d = 1'b1;
                    value_d     = ext_value;
                end else if (sync_confirm) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                enable  = 1'b0;
                clear_c = 1'b0;
                if (stable_c) begin
                    state_d     = ST_WRITE;
                    reg_write_d = 1'b1;
                    value_d     = ext_value;
                end else if (!sync_confirm) begin
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WRITE: begin
                enable  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                enable  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        waiting_d = (state_d == ST_ARM) || (state_d == ST_WAIT_PRESS) ||
                    (state_d == ST_DEBOUNCE);
    end

    // State and output registers; reset aborts any read in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            regWrite   <= 1'b0;
            waiting    <= 1'b0;
            writeValue <= '0;
        end else begin
            state_q    <= state_d;
            regWrite   <= reg_write_d;
            waiting    <= waiting_d;
            writeValue <= value_d;
        end
    end

endmodule

// File: tb/tb_syscall_input.sv
// Bench for syscall_input: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_syscall_input;

    localparam int unsigned SW = 16;
    localparam int unsigned DB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          syscall;
    logic [31:0]   regSValue;
    logic [SW-1:0] switches;
    logic          confirm;
    logic          enable;
    logic          regWrite;
    logic [31:0]   writeValue;
    logic          waiting;

    int checks = 0;
    int passed = 0;
    int dut_writes = 0;

    syscall_input #(
        .READ_CODE      (32'h0000_0005),
        .SWITCH_W       (SW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .syscall   (syscall),
        .regSValue (regSValue),
        .switches  (switches),
        .confirm   (confirm),
        .enable    (enable),
        .regWrite  (regWrite),
        .writeValue(writeValue),
        .waiting   (waiting)
    );

    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ext(input logic [SW-1:0] s);
`ifdef SYSCALL_INPUT_SIGN_EXT_EN
        return {{(32-SW){s[SW-1]}}, s};
`else
        return {{(32-SW){1'b0}}, s};
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: a read is pending once triggered; it first needs a
    // released (synced-low) sample, then DB consecutive synced-high samples.
    bit          m_on = 0;
    bit          m_busy = 0;
    bit          m_rel = 0;
    bit          m_wr = 0;
    int          m_run = 0;
    logic [31:0] m_val = '0;
    bit          c1 = 0;
    bit          c2 = 0;

    initial forever begin
        bit sv;
        bit trig;
        @(posedge clock);
        sv   = c2;
        trig = (syscall === 1'b1) && (regSValue == 32'h5);
        if (reset === 1'b1) begin
            m_on = 1; m_busy = 0; m_rel = 0; m_wr = 0; m_run = 0;
            m_val = '0; c1 = 0; c2 = 0;
        end else begin
            c2 = c1;
            c1 = (confirm === 1'b1);
            if (m_wr) begin
                m_wr = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (trig) begin
                    m_busy = 1; m_rel = 0; m_run = 0;
                end
            end else if (!m_rel) begin
                m_rel = !sv;
            end else if (sv) begin
                m_run++;
                if (m_run >= int'(DB)) begin
                    m_wr  = 1;
                    m_val = ext(switches);
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        bit exp_en;
        @(negedge clock);
        if (m_on) begin
            exp_en = !m_busy && !((syscall === 1'b1) && (regSValue == 32'h5));
            check1("model_enable", enable, exp_en);
            check1("model_regWrite", regWrite, m_wr);
            check1("model_waiting", waiting, m_busy && !m_wr);
            check32("model_writeValue", writeValue, m_val);
            if (regWrite === 1'b1) dut_writes++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic wait_write(input string name);
        bit got;
        got = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (regWrite === 1'b1) begin
                got = 1;
                break;
            end
        end
        check1(name, got, 1'b1);
    endtask

    task automatic trigger_read(input logic [SW-1:0] val);
        switches  = val;
        regSValue = 32'h5;
        syscall   = 1'b1;
        tick();
        syscall   = 1'b0;
        regSValue = 32'h0;
    endtask

    initial begin
        int pulses;
        int at;
        int hold;
        reset = 1'b1; syscall = 1'b0; regSValue = '0; switches = '0; confirm = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check1("rst_enable", enable, 1'b1);
        check1("rst_regWrite", regWrite, 1'b0);
        check1("rst_waiting", waiting, 1'b0);
        check32("rst_writeValue", writeValue, 32'h0);

        // Basic read: write at edge k+5, enable back one cycle later.
        tick();
        switches = 16'h1234; regSValue = 32'h5; syscall = 1'b1;
        #1;
        check1("stall_same_cycle", enable, 1'b0);
        tick();
        syscall = 1'b0; regSValue = 32'h0;
        #1;
        check1("arm_waiting", waiting, 1'b1);
        check1("arm_enable", enable, 1'b0);
        tick();
        confirm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("basic_no_early_write", regWrite, 1'b0);
        end
        tick();
        check1("basic_write_strobe", regWrite, 1'b1);
        check32("basic_write_value", writeValue, 32'h0000_1234);
        check1("basic_enable_in_write", enable, 1'b0);
        confirm = 1'b0;
        tick();
        check1("basic_strobe_one_cycle", regWrite, 1'b0);
        check1("basic_enable_back", enable, 1'b1);
        check32("basic_value_held", writeValue, 32'h0000_1234);

        // Bounce: high 2, low 1, then steady high; one write, 5 edges after the restart.
        tick();
        trigger_read(16'h5A5A);
        tick();
        confirm = 1'b1;
        pulses = 0; at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (regWrite === 1'b1) begin
                pulses++;
                at = i;
            end
            confirm = (i + 1 != 2);
        end
        check32("bounce_pulse_count", 32'(pulses), 32'd1);
        check32("bounce_pulse_edge", 32'(at), 32'd8);

        // Held button: new read while confirm still held stays armed.
        trigger_read(16'h00FF);
        for (int i = 0; i < 10; i++) begin
            tick();
            check1("held_no_write", regWrite, 1'b0);
            check1("held_waiting", waiting, 1'b1);
        end
        confirm = 1'b0;
        tick(); tick(); tick();
        confirm = 1'b1;
        wait_write("held_write_seen");
        check32("held_write_value", writeValue, 32'h0000_00FF);
        confirm = 1'b0;
        tick(); tick(); tick();

        // Ignored codes and confirm activity in IDLE.
        syscall = 1'b1; regSValue = 32'd1;
        #1;
        check1("ignore_print_enable", enable, 1'b1);
        tick();
        regSValue = 32'd10;
        #1;
        check1("ignore_exit_enable", enable, 1'b1);
        tick();
        syscall = 1'b0; regSValue = 32'h0; confirm = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check1("ignore_no_write", regWrite, 1'b0);
            check1("ignore_not_waiting", waiting, 1'b0);
        end
        confirm = 1'b0;
        tick(); tick(); tick();

        // Extension of a negative-looking switch value.
        trigger_read(16'hFFFE);
        confirm = 1'b1;
        wait_write("ext_write_seen");
`ifdef SYSCALL_INPUT_SIGN_EXT_EN
        check32("ext_value", writeValue, 32'hFFFF_FFFE);
`else
        check32("ext_value", writeValue, 32'h0000_FFFE);
`endif
        confirm = 1'b0;
        tick(); tick(); tick();

        // Reset during DEBOUNCE (count 2) with a coincident trigger.
        trigger_read(16'h4321);
        tick();
        confirm = 1'b1;
        tick(); tick(); tick(); tick();
        check1("pre_reset_waiting", waiting, 1'b1);
        reset = 1'b1; syscall = 1'b1; regSValue = 32'h5;
        tick();
        reset = 1'b0; syscall = 1'b0; regSValue = 32'h0;
        #1;
        check1("reset_mid_enable", enable, 1'b1);
        check1("reset_mid_waiting", waiting, 1'b0);
        check32("reset_mid_value", writeValue, 32'h0);
        check1("reset_mid_regWrite", regWrite, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check1("reset_mid_no_write", regWrite, 1'b0);
        end
        confirm = 1'b0;
        tick(); tick(); tick();

        // Randomized traffic, checked by the per-cycle model comparison.
        dut_writes = 0;
        hold = 0;
        repeat (3000) begin
            tick();
            if (hold == 0) begin
                confirm = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 9));
            end
            hold--;
            syscall = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0, 1:    regSValue = 32'h5;
                2:       regSValue = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'd10;
                default: regSValue = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) switches = SW'($urandom);
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0; syscall = 1'b0;
        tick(); tick();
        check1("random_writes_seen", dut_writes > 0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
